// File: rtl/data_sampling.sv
// data_sampling: UART RX oversampling stage ahead of the deserializer.
// Takes three samples of rx_in at edge_counter = mid-1, mid, mid+1 (mid = prescale/2),
// majority-votes them and publishes the result one clock later, so sampled_bit is
// stable before the deserializer captures at edge_counter == prescale-1.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   dat_samp_en  sampling enable from the RX FSM
//   prescale     clocks per bit, legal range 6 .. 2^EDGE_W
//   edge_counter clock index within the current bit
//   rx_in        synchronized serial line
//   sampled_bit  majority-voted bit value (holds between updates)
//   sample_done  one-cycle strobe, sampled_bit updated this cycle
//   noise_err    the three samples of the last bit disagreed
//   cfg_err      prescale is outside the legal range (registered)
module data_sampling #(
    parameter int unsigned EDGE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dat_samp_en,
    input  logic [EDGE_W:0]   prescale,
    input  logic [EDGE_W-1:0] edge_counter,
    input  logic              rx_in,
    output logic              sampled_bit,
    output logic              sample_done,
    output logic              noise_err,
    output logic              cfg_err
);

    localparam int unsigned PW = EDGE_W + 1;
    localparam logic [PW-1:0] PsMin = PW'(6);
    localparam logic [PW-1:0] PsMax = PW'(2 ** EDGE_W);

    logic          s0_q, s0_d;
    logic          s1_q, s1_d;
    logic          bit_q, bit_d;
    logic          done_q, done_d;
    logic          noise_q, noise_d;
    logic          cfg_q, cfg_d;

    logic [PW-1:0] mid;
    logic [PW-1:0] ec_ext;
    logic          in_range;
    logic          hit_s0, hit_s1, hit_vote;
    logic          maj;
    logic          noisy;

    always_comb begin
        mid      = prescale >> 1;
        ec_ext   = {1'b0, edge_counter};
        in_range = (ec_ext < prescale);
        // With an illegal prescale mid-1 may wrap; cfg_q blocks use of these anyway.
        hit_s0   = (ec_ext == mid - PW'(1));
        hit_s1   = (ec_ext == mid);
        hit_vote = (ec_ext == mid + PW'(1));
        // Third sample comes straight from the line and is never stored.
        maj      = (s0_q & s1_q) | (s0_q & rx_in) | (s1_q & rx_in);
        noisy    = !((s0_q == s1_q) && (s1_q == rx_in));
    end

    always_comb begin
        s0_d    = s0_q;
        s1_d    = s1_q;
        bit_d   = bit_q;
        noise_d = noise_q;
        done_d  = 1'b0;
        cfg_d   = (prescale < PsMin) || (prescale > PsMax);

        if (!dat_samp_en) begin
            // Idle line level; a bit interrupted by the enable is discarded.
            s0_d = 1'b1;
            s1_d = 1'b1;
        end else if (!cfg_q && in_range) begin
            if (hit_s0) s0_d = rx_in;
            if (hit_s1) s1_d = rx_in;
            if (hit_vote) begin
                bit_d   = maj;
                noise_d = noisy;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            bit_q   <= 1'b1;
            done_q  <= 1'b0;
            noise_q <= 1'b0;
            cfg_q   <= 1'b0;
        end else begin
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
            noise_q <= noise_d;
            cfg_q   <= cfg_d;
        end
    end

    assign sampled_bit = bit_q;
    assign sample_done = done_q;
    assign noise_err   = noise_q;
    assign cfg_err     = cfg_q;

endmodule

// File: tb/tb_data_sampling.sv
// tb_data_sampling: directed test-plan scenarios plus randomized bits, every cycle
// compared against a bit-level reference model of the sampling rules.
module tb_data_sampling;

    logic       clk;
    logic       rst;
    logic       dat_samp_en;
    logic [4:0] prescale;
    logic [3:0] edge_counter;
    logic       rx_in;
    logic       sampled_bit;
    logic       sample_done;
    logic       noise_err;
    logic       cfg_err;

    data_sampling #(.EDGE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .dat_samp_en  (dat_samp_en),
        .prescale     (prescale),
        .edge_counter (edge_counter),
        .rx_in        (rx_in),
        .sampled_bit  (sampled_bit),
        .sample_done  (sample_done),
        .noise_err    (noise_err),
        .cfg_err      (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int done_at = -1;

    // Reference model state: the three sample points of the current bit.
    logic m_bit, m_done, m_noise, m_cfg;
    logic m_pts [3];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update();
        logic cfg_old;
        int   k;
        int   ones;
        if (rst) begin
            m_bit = 1'b1; m_done = 1'b0; m_noise = 1'b0; m_cfg = 1'b0;
            for (int i = 0; i < 3; i++) m_pts[i] = 1'b1;
            return;
        end
        cfg_old = m_cfg;
        m_cfg   = !(prescale >= 6 && prescale <= 16);
        m_done  = 1'b0;
        if (!dat_samp_en) begin
            for (int i = 0; i < 3; i++) m_pts[i] = 1'b1;
        end else if (!cfg_old && int'(edge_counter) < int'(prescale)) begin
            k = int'(edge_counter) - int'(prescale) / 2 + 1;
            if (k == 0 || k == 1) begin
                m_pts[k] = rx_in;
            end else if (k == 2) begin
                ones    = int'(m_pts[0]) + int'(m_pts[1]) + int'(rx_in);
                m_bit   = (ones >= 2);
                m_noise = (ones == 1 || ones == 2);
                m_done  = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        check_eq("sampled_bit", sampled_bit, m_bit);
        check_eq("sample_done", sample_done, m_done);
        check_eq("noise_err", noise_err, m_noise);
        check_eq("cfg_err", cfg_err, m_cfg);
        if (sample_done) begin
            done_seen++;
            done_at = int'(edge_counter) + 1;
        end
    endtask

    // One bit period; bit e of each pattern applies at edge_counter == e.
    task automatic run_bit(input int p, input logic [31:0] rxpat, input logic [31:0] enpat,
                           input logic [31:0] rstpat);
        for (int e = 0; e < p; e++) begin
            prescale     = 5'(p);
            edge_counter = 4'(e);
            rx_in        = rxpat[e];
            dat_samp_en  = enpat[e];
            rst          = rstpat[e];
            tick();
        end
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rxpat, enpat, rstpat;
        int p, k;
        rst = 1'b1; dat_samp_en = 1'b0; prescale = 5'd8; edge_counter = 4'd0; rx_in = 1'b1;
        tick();
        tick();
        check_eq("rst_bit", sampled_bit, 1);
        check_eq("rst_done", sample_done, 0);
        check_eq("rst_noise", noise_err, 0);
        check_eq("rst_cfg", cfg_err, 0);
        rst = 1'b0;

        // Clean bits at prescale 8.
        done_seen = 0;
        run_bit(8, 32'h0, '1, 0);
        check_eq("clean0_bit", sampled_bit, 0);
        check_eq("clean0_noise", noise_err, 0);
        check_eq("clean0_cnt", done_seen, 1);
        check_eq("clean0_edge", done_at, 6);
        run_bit(8, '1, '1, 0);
        check_eq("clean1_bit", sampled_bit, 1);

        // Glitch at edge 4, then a clean bit clears noise.
        run_bit(8, ~(32'h1 << 4), '1, 0);
        check_eq("glitch_bit", sampled_bit, 1);
        check_eq("glitch_noise", noise_err, 1);
        run_bit(8, '1, '1, 0);
        check_eq("glitch_clear", noise_err, 0);

        // Prescale 16: samples 0,1,0 at edges 7..9, glitch at edge 3 ignored.
        done_seen = 0;
        run_bit(16, (32'h1 << 8) | (32'h1 << 3), '1, 0);
        check_eq("ps16_bit", sampled_bit, 0);
        check_eq("ps16_noise", noise_err, 1);
        check_eq("ps16_edge", done_at, 10);
        check_eq("ps16_cnt", done_seen, 1);

        // Enable drop at edge 4: no strobe, prior value 0 held; then a normal bit.
        done_seen = 0;
        run_bit(8, '1, 32'h0000_000F, 0);
        check_eq("drop_cnt", done_seen, 0);
        check_eq("drop_hold", sampled_bit, 0);
        run_bit(8, '1, '1, 0);
        check_eq("reen_bit", sampled_bit, 1);
        check_eq("reen_cnt", done_seen, 1);

        // Illegal prescale.
        prescale = 5'd4; edge_counter = 4'd0; dat_samp_en = 1'b1; rx_in = 1'b0;
        tick();
        check_eq("ill_cfg", cfg_err, 1);
        done_seen = 0;
        for (int b = 0; b < 3; b++) run_bit(4, 32'h0, '1, 0);
        check_eq("ill_cnt", done_seen, 0);
        check_eq("ill_hold", sampled_bit, 1);
        run_bit(8, 32'h0, '1, 0);
        check_eq("fix_cfg", cfg_err, 0);
        check_eq("fix_bit", sampled_bit, 0);
        check_eq("fix_cnt", done_seen, 1);

        // Reset from edge 4 to the end of the bit while rx_in = 0.
        done_seen = 0;
        run_bit(8, 32'h0, '1, 32'hF0);
        check_eq("rstmid_bit", sampled_bit, 1);
        check_eq("rstmid_noise", noise_err, 0);
        check_eq("rstmid_cnt", done_seen, 0);
        run_bit(8, 32'h0, '1, 0);
        check_eq("post_rst_bit", sampled_bit, 0);
        check_eq("post_rst_cnt", done_seen, 1);

        // Randomized bits with glitches, enable drops/rises, resets and bad configs.
        for (int b = 0; b < 300; b++) begin
            p = ($urandom_range(0, 19) == 0) ? $urandom_range(4, 5) : $urandom_range(6, 16);
            rxpat = $urandom_range(0, 1) ? '1 : '0;
            for (int e = 0; e < 16; e++)
                if ($urandom_range(0, 9) == 0) rxpat[e] = ~rxpat[e];
            enpat  = '1;
            rstpat = '0;
            k = $urandom_range(0, p - 1);
            case ($urandom_range(0, 19))
                0, 1: enpat = (32'h1 << k) - 1;
                2, 3: enpat = ~((32'h1 << k) - 1);
                4:    rstpat = 32'h1 << k;
                default: ;
            endcase
            run_bit(p, rxpat, enpat, rstpat);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
